usb_line_monitor: RTL and testbench

Parametrised USB bus-condition monitor: filters the PHY line state and detects bus reset, suspend and resume with cycle-count thresholds set at elaboration. It replaces the fixed-period SE0-only reset detector and sits between the PHY line-state decoder and the device core reset/power logic. It provides a level reset, a reset-start pulse, a suspend level and a resume pulse. Defaults target full speed at 48 MHz.

---
 rtl/usb_line_monitor_if.sv | 20 ++
 rtl/usb_line_monitor.sv | 141 ++++++++++++++
 tb/tb_usb_line_monitor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/usb_line_monitor_if.sv
// Line-state in / bus-condition out bundle between the PHY decoder and the line monitor.
// The monitor takes the slave modport. The PHY side, or a bench, takes the master modport.
interface usb_line_monitor_if;
  logic [1:0] line_state;
  logic       reset_o;
  logic       reset_start_o;
  logic       suspend_o;
  logic       resume_o;
  logic [1:0] state_o;

  modport master (
    output line_state,
    input  reset_o, reset_start_o, suspend_o, resume_o, state_o
  );

  modport slave (
    input  line_state,
    output reset_o, reset_start_o, suspend_o, resume_o, state_o
  );
endinterface

// File: rtl/usb_line_monitor.sv
// USB bus-condition monitor: run-length filters line_state and flags bus reset, suspend and resume.
// Build option USB_LINE_MON_SUSPEND_EN adds the SUSPEND state, J-idle detection and K resume.
module usb_line_monitor #(
  parameter int RESET_CYCLES   = 128,
  parameter int SUSPEND_CYCLES = 144000,
  parameter int RESUME_CYCLES  = 4800
) (
  input  logic                 clk,
  input  logic                 reset_ni,
  usb_line_monitor_if.slave    bus
);

`ifdef USB_LINE_MON_SUSPEND_EN
  localparam int MAX_RS = (RESET_CYCLES > SUSPEND_CYCLES) ? RESET_CYCLES : SUSPEND_CYCLES;
  localparam int MAXC   = (MAX_RS > RESUME_CYCLES) ? MAX_RS : RESUME_CYCLES;
`else
  localparam int MAXC   = RESET_CYCLES;
`endif
  localparam int CW = $clog2(MAXC + 1);

  if (RESET_CYCLES < 2) begin : g_bad_reset
    $error("usb_line_monitor: RESET_CYCLES must be >= 2");
  end
`ifdef USB_LINE_MON_SUSPEND_EN
  if (SUSPEND_CYCLES <= RESET_CYCLES) begin : g_bad_suspend
    $error("usb_line_monitor: SUSPEND_CYCLES must exceed RESET_CYCLES");
  end
  if (RESUME_CYCLES < 2) begin : g_bad_resume
    $error("usb_line_monitor: RESUME_CYCLES must be >= 2");
  end
`else
  if (SUSPEND_CYCLES < 0 || RESUME_CYCLES < 0) begin : g_ignored
    $info("usb_line_monitor: suspend thresholds are ignored in this build");
  end
`endif

  // The sample classes reuse the line_state encoding. SE1 therefore lands on OTHER.
  typedef enum logic [1:0] {C_SE0 = 2'b00, C_J = 2'b01, C_K = 2'b10, C_OTHER = 2'b11} cls_e;
  typedef enum logic [1:0] {S_ACTIVE = 2'b00, S_RESET = 2'b01, S_SUSPEND = 2'b10} st_e;

  st_e           state_q;
  cls_e          cls_q, smp;
  logic [CW-1:0] run_q, run_next;
  logic          same, sat, fresh;
  logic          hit_rst;
  logic          reset_q, rst_start_q;
`ifdef USB_LINE_MON_SUSPEND_EN
  logic          hit_susp, hit_res;
  logic          susp_q, resume_q;
`endif

  always_comb begin
    smp      = cls_e'(bus.line_state);
    same     = (smp == cls_q);
    sat      = &run_q;
    run_next = !same ? CW'(1) : (sat ? run_q : run_q + CW'(1));
    // A saturated count that is only holding is not a new arrival at the threshold.
    // This keeps each threshold to one hit per run, even when N is all-ones.
    fresh    = !(same && sat);
    hit_rst  = fresh && (smp == C_SE0) && (run_next == CW'(RESET_CYCLES));
`ifdef USB_LINE_MON_SUSPEND_EN
    hit_susp = fresh && (smp == C_J) && (run_next == CW'(SUSPEND_CYCLES));
    hit_res  = fresh && (smp == C_K) && (run_next == CW'(RESUME_CYCLES));
`endif
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_ACTIVE;
      cls_q       <= C_OTHER;
      run_q       <= '0;
      reset_q     <= 1'b0;
      rst_start_q <= 1'b0;
`ifdef USB_LINE_MON_SUSPEND_EN
      susp_q      <= 1'b0;
      resume_q    <= 1'b0;
`endif
    end else begin
      run_q       <= run_next;
      cls_q       <= smp;
      rst_start_q <= 1'b0;
`ifdef USB_LINE_MON_SUSPEND_EN
      resume_q    <= 1'b0;
`endif
      case (state_q)
        S_ACTIVE: begin
          if (hit_rst) begin
            state_q     <= S_RESET;
            reset_q     <= 1'b1;
            rst_start_q <= 1'b1;
          end
`ifdef USB_LINE_MON_SUSPEND_EN
          else if (hit_susp) begin
            state_q <= S_SUSPEND;
            susp_q  <= 1'b1;
          end
`endif
        end
        S_RESET: begin
          if (smp != C_SE0) begin
            state_q <= S_ACTIVE;
            reset_q <= 1'b0;
          end
        end
`ifdef USB_LINE_MON_SUSPEND_EN
        S_SUSPEND: begin
          if (hit_res) begin
            state_q  <= S_ACTIVE;
            susp_q   <= 1'b0;
            resume_q <= 1'b1;
          end else if (hit_rst) begin
            state_q     <= S_RESET;
            susp_q      <= 1'b0;
            reset_q     <= 1'b1;
            rst_start_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_ACTIVE;
          reset_q <= 1'b0;
`ifdef USB_LINE_MON_SUSPEND_EN
          susp_q  <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.reset_o       = reset_q;
  assign bus.reset_start_o = rst_start_q;
  assign bus.state_o       = state_q;
`ifdef USB_LINE_MON_SUSPEND_EN
  assign bus.suspend_o     = susp_q;
  assign bus.resume_o      = resume_q;
`else
  assign bus.suspend_o     = 1'b0;
  assign bus.resume_o      = 1'b0;
`endif

endmodule

// File: tb/tb_usb_line_monitor.sv
// Bench for usb_line_monitor. Directed runs plus random run bursts are checked against a
// reference that applies the bus-condition rules directly to a run-length count.
module tb_usb_line_monitor;
  localparam int RC  = 8;
  localparam int SC  = 32;
  localparam int RMC = 4;
`ifdef USB_LINE_MON_SUSPEND_EN
  localparam bit SUSP_EN = 1'b1;
`else
  localparam bit SUSP_EN = 1'b0;
`endif

  localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10, SE1 = 2'b11;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  usb_line_monitor_if bus();

  usb_line_monitor #(.RESET_CYCLES(RC), .SUSPEND_CYCLES(SC), .RESUME_CYCLES(RMC)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // The reference keeps an unbounded run length. Bus mode: 0 active, 1 reset, 2 suspended.
  int m_mode = 0;
  int m_cls  = 3;
  int m_run  = 0;
  bit m_rs   = 1'b0;
  bit m_res  = 1'b0;
  int starts = 0;

  function automatic logic [5:0] expected();
    return {m_mode == 1, m_rs, m_mode == 2, m_res, 2'(m_mode)};
  endfunction

  function automatic logic [5:0] observed();
    return {bus.reset_o, bus.reset_start_o, bus.suspend_o, bus.resume_o, bus.state_o};
  endfunction

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cls = 3; m_run = 0; m_rs = 1'b0; m_res = 1'b0;
  endtask

  task automatic model_sample(input logic [1:0] ls);
    int c;
    c = int'(ls);
    if (c == m_cls) m_run++;
    else begin m_cls = c; m_run = 1; end
    m_rs  = 1'b0;
    m_res = 1'b0;
    if (m_mode == 0) begin
      if (c == 0 && m_run == RC) begin m_mode = 1; m_rs = 1'b1; end
      else if (SUSP_EN && c == 1 && m_run == SC) m_mode = 2;
    end else if (m_mode == 1) begin
      if (c != 0) m_mode = 0;
    end else begin
      if (c == 2 && m_run == RMC) begin m_mode = 0; m_res = 1'b1; end
      else if (c == 0 && m_run == RC) begin m_mode = 1; m_rs = 1'b1; end
    end
  endtask

  task automatic step(input string tag, input logic [1:0] ls);
    bus.line_state = ls;
    @(posedge clk);
    model_sample(ls);
    #1;
    if (bus.reset_start_o === 1'b1) starts++;
    chk(tag, observed(), expected());
  endtask

  task automatic run(input string tag, input logic [1:0] ls, input int n);
    for (int i = 0; i < n; i++) step(tag, ls);
  endtask

  initial begin
    bus.line_state = J;
    #12;
    model_reset();
    chk("reset_state", observed(), 6'b0);
    @(negedge clk);
    reset_ni = 1'b1;

    run("se0_short", SE0, RC - 1);
    run("j_after_short", J, 1);
    run("se0_reset", SE0, RC);
    chk("reset_edge", observed(), 6'b110001);
    run("se0_hold1", SE0, 1);
    chk("start_drop", observed(), 6'b100001);
    run("j_release", J, 1);
    chk("release", observed(), 6'b000000);

    starts = 0;
    run("se0_long", SE0, 5000);
    tests++;
    assert (starts === 1) else begin
      fails++;
      $error("FAIL start_once: observed %0d expected %0d", starts, 1);
    end
    run("j_exit_long", J, 1);

    run("j_idle", J, SC);
    chk("suspend_edge", observed(), SUSP_EN ? 6'b001010 : 6'b000000);
    run("k_glitch", K, RMC - 1);
    run("j_between", J, 1);
    run("k_resume", K, RMC);
    chk("resume_edge", observed(), SUSP_EN ? 6'b000100 : 6'b000000);
    run("k_after", K, 1);

    run("j_idle2", J, SC);
    run("se0_in_susp", SE0, RC);
    chk("susp_to_reset", observed(), 6'b110001);
    run("j_out", J, 1);

    run("se0_pre_se1", SE0, 4);
    run("se1_break", SE1, 1);
    run("se0_post_se1", SE0, RC);
    chk("se1_se0_restart", observed(), 6'b110001);
    run("j_pre_se1", J, 19);
    run("se1_break_j", SE1, 1);
    run("j_post_se1", J, SC);
    chk("se1_j_restart", observed(), SUSP_EN ? 6'b001010 : 6'b000000);
    run("k_wake", K, RMC);

    run("se0_pre_arst", SE0, 6);
    #2;
    reset_ni = 1'b0;
    model_reset();
    #1;
    chk("async_clear", observed(), 6'b0);
    @(negedge clk);
    reset_ni = 1'b1;
    run("se0_post_arst", SE0, RC - 1);
    chk("no_early_reset", observed(), 6'b0);
    run("se0_post_arst_n", SE0, 1);
    chk("reset_after_arst", observed(), 6'b110001);
    run("j_40", J, 40);
    chk("j_40_state", observed(), SUSP_EN ? 6'b001010 : 6'b000000);

    for (int b = 0; b < 300; b++) begin
      logic [1:0] ls;
      int len;
      ls  = 2'($urandom_range(0, 3));
      len = (ls == J) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
      run("random", ls, len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
